// File: rtl/wb_write_buffer_pkg.sv
// Shared types and constants for the register-file write buffer.
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    typedef struct packed {
        logic [REG_AW-1:0] reg_idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_write_buffer_if.sv
// Producer, register-file and lookup signals of the write buffer.
// Optional WB_BUF_FWD_EN adds the q_data1/q_data2 forwarding outputs.
interface wb_write_buffer_if
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = clog2(DEPTH) + 1;

    logic              mem_valid;
    logic [REG_AW-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              wr_en;
    logic [REG_AW-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [REG_AW-1:0] q_reg1;
    logic [REG_AW-1:0] q_reg2;
    logic              q_pend1;
    logic              q_pend2;
    logic [CW-1:0]     count;
`ifdef WB_BUF_FWD_EN
    logic [DATA_W-1:0] q_data1;
    logic [DATA_W-1:0] q_data2;

    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, q_reg1, q_reg2,
        output mem_ready, alu_ready, wr_en, wr_reg, wr_data, q_pend1, q_pend2, count,
               q_data1, q_data2
    );
    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, q_reg1, q_reg2,
        input  mem_ready, alu_ready, wr_en, wr_reg, wr_data, q_pend1, q_pend2, count,
               q_data1, q_data2
    );
`else
    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, q_reg1, q_reg2,
        output mem_ready, alu_ready, wr_en, wr_reg, wr_data, q_pend1, q_pend2, count
    );
    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, q_reg1, q_reg2,
        input  mem_ready, alu_ready, wr_en, wr_reg, wr_data, q_pend1, q_pend2, count
    );
`endif

endinterface

// File: rtl/wb_write_buffer_match.sv
// Pending-write lookup for one query register over the age-ordered entries.
// Youngest-match data output exists only with WB_BUF_FWD_EN.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      [REG_AW-1:0] q_reg,
    input  wb_entry_t [DEPTH-1:0]  entries,
    input  logic      [DEPTH-1:0]  valid,
`ifdef WB_BUF_FWD_EN
    output logic      [DATA_W-1:0] data,
`endif
    output logic                   pend
);

    // entries[0] is the oldest; later matches overwrite, so the youngest wins.
    always_comb begin
        pend = 1'b0;
`ifdef WB_BUF_FWD_EN
        data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && (entries[k].reg_idx == q_reg) && (q_reg != '0)) begin
                pend = 1'b1;
`ifdef WB_BUF_FWD_EN
                data = entries[k].data;
`endif
            end
        end
    end

`ifndef WB_BUF_FWD_EN
    logic unused_data;
    always_comb begin
        unused_data = 1'b0;
        for (int k = 0; k < DEPTH; k++) unused_data = unused_data ^ (^entries[k].data);
    end
`endif

endmodule

// File: rtl/wb_write_buffer.sv
// In-order write buffer in front of the register file write port (mem + ALU producers).
// Optional WB_BUF_FWD_EN enables youngest-match data forwarding on the lookups.
module wb_write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    wb_write_buffer_if.slave bus
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] slots;
    wb_entry_t [DEPTH-1:0] ordered;
    logic      [DEPTH-1:0] valid;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         alu_slot;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         free;
    logic                  mem_acc;
    logic                  alu_acc;
    logic                  mem_push;
    logic                  alu_push;
    logic                  pop;

    // Space comes from the registered count only, keeping ready off the drain path.
    assign free          = CW'(DEPTH) - cnt;
    assign bus.mem_ready = (free >= CW'(1));
    assign bus.alu_ready = (bus.mem_valid && bus.mem_ready) ? (free >= CW'(2)) : (free >= CW'(1));

    assign mem_acc  = bus.mem_valid && bus.mem_ready;
    assign alu_acc  = bus.alu_valid && bus.alu_ready;
    assign mem_push = mem_acc && (bus.mem_reg != '0);
    assign alu_push = alu_acc && (bus.alu_reg != '0);
    assign pop      = (cnt != '0);
    assign alu_slot = tail + PW'(mem_push);

    always_ff @(posedge clk) begin
        if (mem_push) slots[tail]     <= '{reg_idx: bus.mem_reg, data: bus.mem_data};
        if (alu_push) slots[alu_slot] <= '{reg_idx: bus.alu_reg, data: bus.alu_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(pop);
            tail <= tail + PW'(mem_push) + PW'(alu_push);
            cnt  <= cnt + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    assign bus.wr_en   = pop;
    assign bus.wr_reg  = pop ? slots[head].reg_idx : '0;
    assign bus.wr_data = pop ? slots[head].data : '0;
    assign bus.count   = cnt;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ordered[k] = slots[head + PW'(k)];
            valid[k]   = (CW'(k) < cnt);
        end
    end

    wb_match #(.DEPTH(DEPTH)) u_match1 (
        .q_reg   (bus.q_reg1),
        .entries (ordered),
        .valid   (valid),
`ifdef WB_BUF_FWD_EN
        .data    (bus.q_data1),
`endif
        .pend    (bus.q_pend1)
    );

    wb_match #(.DEPTH(DEPTH)) u_match2 (
        .q_reg   (bus.q_reg2),
        .entries (ordered),
        .valid   (valid),
`ifdef WB_BUF_FWD_EN
        .data    (bus.q_data2),
`endif
        .pend    (bus.q_pend2)
    );

endmodule

// File: tb/tb_wb_write_buffer.sv
// Scoreboard bench for wb_write_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the buffer.
module tb_wb_write_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    wb_entry_t mq[$];   // model contents, oldest first
    wb_entry_t sb[$];   // expected register-file writes

    wb_write_buffer_if #(.DEPTH(DEPTH)) bus ();

    wb_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        else n_pass = n_pass + 1;
    endfunction

    function automatic void model_lookup(input logic [3:0] q, output logic pend, output logic [15:0] data);
        pend = 1'b0;
        data = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!pend && mq[i].reg_idx == q) begin
                pend = 1'b1;
                data = mq[i].data;
            end
        end
    endfunction

    // Monitor: every observed register-file write must match the next expected one.
    always @(negedge clk) begin
        wb_entry_t e;
        if (!rst) begin
            chk("wr_en", bus.wr_en, sb.size() != 0);
            if (bus.wr_en && sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_reg", bus.wr_reg, e.reg_idx);
                chk("wr_data", bus.wr_data, e.data);
            end else if (!bus.wr_en) begin
                chk("wr_reg_idle", bus.wr_reg, 0);
                chk("wr_data_idle", bus.wr_data, 0);
            end
        end
    end

    task automatic set_idle();
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.q_reg1 = '0; bus.q_reg2 = '0;
    endtask

    task automatic cycle(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad,
                         input logic [3:0] q1, input logic [3:0] q2);
        int n;
        logic exp_mr, exp_ar, p1, p2;
        logic [15:0] d1, d2;
        @(negedge clk);
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.q_reg1 = q1; bus.q_reg2 = q2;
        #1;
        n = mq.size();
        exp_mr = (DEPTH - n) >= 1;
        exp_ar = (mv && exp_mr) ? ((DEPTH - n) >= 2) : ((DEPTH - n) >= 1);
        chk("mem_ready", bus.mem_ready, exp_mr);
        chk("alu_ready", bus.alu_ready, exp_ar);
        chk("count", bus.count, n);
        model_lookup(q1, p1, d1);
        model_lookup(q2, p2, d2);
        chk("q_pend1", bus.q_pend1, p1);
        chk("q_pend2", bus.q_pend2, p2);
`ifdef WB_BUF_FWD_EN
        chk("q_data1", bus.q_data1, d1);
        chk("q_data2", bus.q_data2, d2);
`endif
        // Effect of the coming edge: drain the oldest, then enqueue mem before ALU.
        if (n != 0) void'(mq.pop_front());
        if (mv && exp_mr && mr != 0) begin
            mq.push_back('{reg_idx: mr, data: md});
            sb.push_back('{reg_idx: mr, data: md});
        end
        if (av && exp_ar && ar != 0) begin
            mq.push_back('{reg_idx: ar, data: ad});
            sb.push_back('{reg_idx: ar, data: ad});
        end
    endtask

    task automatic idle(input int n, input logic [3:0] q1, input logic [3:0] q2);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_reg", bus.wr_reg, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_mem_ready", bus.mem_ready, 1);
        chk("rst_alu_ready", bus.alu_ready, 1);
        chk("rst_q_pend1", bus.q_pend1, 0);
        rst = 1'b0;

        idle(2, 0, 0);
        cycle(0, 0, 0, 1, 4'd5, 16'hBEEF, 4'd5, 4'd6);
        idle(3, 4'd5, 4'd6);

        cycle(1, 4'd3, 16'h1111, 1, 4'd3, 16'h2222, 4'd3, 4'd3);
        idle(4, 4'd3, 4'd0);

        cycle(0, 0, 0, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
        idle(2, 4'd0, 4'd0);

        for (int i = 0; i < 6; i++)
            cycle(1, 4'($urandom_range(1, 15)), 16'($urandom), 1, 4'($urandom_range(1, 15)),
                  16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        idle(5, 4'd1, 4'd2);

        // Asynchronous reset while entries are still queued.
        for (int i = 0; i < 3; i++)
            cycle(1, 4'(i + 7), 16'($urandom), 1, 4'(i + 10), 16'($urandom), 4'd7, 4'd10);
        @(posedge clk);
        #2;
        set_idle();
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", bus.wr_en, 0);
        chk("midrst_count", bus.count, 0);
        chk("midrst_q_pend", bus.q_pend1, 0);
        chk("midrst_alu_ready", bus.alu_ready, 1);
        mq.delete();
        sb.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            cycle(1, 4'(i + 1), 16'(16'hA000 + i), 0, 0, 0, 4'(i + 1), 4'(i));
        idle(3, 0, 0);

        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, 4'($urandom_range(0, 5)), 16'($urandom),
                  ($urandom % 3) != 0, 4'($urandom_range(0, 5)), 16'($urandom),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
        idle(6, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
